// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one 32-bit ALU between two requesters. A round-robin arbiter picks a
// requester in IDLE, the chosen operands are registered onto the ALU inputs
// (together with the pre-shifted B operand), the ALU is given EXEC_CYCLES
// cycles to settle, and the captured BusW/Zero is returned with the
// requester id over a valid/ready response channel.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   reqN_valid/ready      request handshake for requester N (N = 0, 1)
//   reqN_ctrl/a/b/shmt    ALU control code, operands and shift amount
//   alu_busa/busb/ctrl    registered ALU inputs
//   alu_shmt/shift        registered shift amount and (busb >> shmt)
//   alu_busw/alu_zero     ALU result and zero flag
//   rsp_valid/ready       response handshake
//   rsp_id/data/zero/err  requester index, captured result, zero flag,
//                         unassigned-control-code flag
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_ctrl,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [4:0]  req0_shmt,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_ctrl,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [4:0]  req1_shmt,
   output logic [31:0] alu_busa,
   output logic [31:0] alu_busb,
   output logic [31:0] alu_shift,
   output logic [3:0]  alu_ctrl,
   output logic [4:0]  alu_shmt,
   input  logic [31:0] alu_busw,
   input  logic        alu_zero,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        rsp_zero,
   output logic        rsp_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Counter load value: the ALU inputs are held EXEC_CYCLES cycles before capture.
   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   // Codes 0101 and 1111 are not decoded by the ALU; they are flagged, not blocked.
   function automatic logic is_unassigned(input logic [3:0] ctrl);
      return (ctrl == 4'b0101) || (ctrl == 4'b1111);
   endfunction

   state_e      state_q,      state_d;
   logic        last_grant_q, last_grant_d;
   logic [3:0]  cnt_q,        cnt_d;
   logic [31:0] busa_q,       busa_d;
   logic [31:0] busb_q,       busb_d;
   logic [31:0] shift_q,      shift_d;
   logic [3:0]  ctrl_q,       ctrl_d;
   logic [4:0]  shmt_q,       shmt_d;
   logic        id_q,         id_d;
   logic        err_q,        err_d;
   logic        rsp_valid_q,  rsp_valid_d;
   logic        rsp_id_q,     rsp_id_d;
   logic [31:0] rsp_data_q,   rsp_data_d;
   logic        rsp_zero_q,   rsp_zero_d;
   logic        rsp_err_q,    rsp_err_d;

   logic        grant_vld_s;
   logic        grant_id_s;
   logic        accept_s;
   logic [3:0]  sel_ctrl_s;
   logic [31:0] sel_a_s;
   logic [31:0] sel_b_s;
   logic [4:0]  sel_shmt_s;

   // Round-robin grant: on a tie the port that did not win last time is chosen.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_vld_s = 1'b1;
         grant_id_s  = ~last_grant_q;
      end else if (req0_valid) begin
         grant_vld_s = 1'b1;
         grant_id_s  = 1'b0;
      end else if (req1_valid) begin
         grant_vld_s = 1'b1;
         grant_id_s  = 1'b1;
      end else begin
         grant_vld_s = 1'b0;
         grant_id_s  = 1'b0;
      end
   end

   assign accept_s   = (state_q == ST_IDLE) && grant_vld_s;
   assign req0_ready = accept_s && !grant_id_s;
   assign req1_ready = accept_s &&  grant_id_s;

   assign sel_ctrl_s = grant_id_s ? req1_ctrl : req0_ctrl;
   assign sel_a_s    = grant_id_s ? req1_a    : req0_a;
   assign sel_b_s    = grant_id_s ? req1_b    : req0_b;
   assign sel_shmt_s = grant_id_s ? req1_shmt : req0_shmt;

   // Next-state logic: every register holds unless its state says otherwise.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      busa_d       = busa_q;
      busb_d       = busb_q;
      shift_d      = shift_q;
      ctrl_d       = ctrl_q;
      shmt_d       = shmt_q;
      id_d         = id_q;
      err_d        = err_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_vld_s) begin
               busa_d       = sel_a_s;
               busb_d       = sel_b_s;
               shift_d      = sel_b_s >> sel_shmt_s;
               ctrl_d       = sel_ctrl_s;
               shmt_d       = sel_shmt_s;
               id_d         = grant_id_s;
               err_d        = is_unassigned(sel_ctrl_s);
               last_grant_d = grant_id_s;
               cnt_d        = CNT_LOAD;
               state_d      = ST_EXEC;
            end else begin
               state_d      = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (cnt_q == 4'd0) begin
               rsp_data_d  = alu_busw;
               rsp_zero_d  = alu_zero;
               rsp_id_d    = id_q;
               rsp_err_d   = err_q;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d       = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State register; reset aborts any in-flight operation.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= 4'd0;
         busa_q       <= 32'd0;
         busb_q       <= 32'd0;
         shift_q      <= 32'd0;
         ctrl_q       <= 4'd0;
         shmt_q       <= 5'd0;
         id_q         <= 1'b0;
         err_q        <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= 32'd0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         busa_q       <= busa_d;
         busb_q       <= busb_d;
         shift_q      <= shift_d;
         ctrl_q       <= ctrl_d;
         shmt_q       <= shmt_d;
         id_q         <= id_d;
         err_q        <= err_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign alu_busa  = busa_q;
   assign alu_busb  = busb_q;
   assign alu_shift = shift_q;
   assign alu_ctrl  = ctrl_q;
   assign alu_shmt  = shmt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_zero  = rsp_zero_q;
   assign rsp_err   = rsp_err_q;

endmodule
